// File: rtl/slm_cmd_parser.sv
// slm_cmd_parser: parses SYNC/CMD/ADDR/DATA/CSUM UART frames, runs one SPI transfer, replies ACK/NAK/read data.
// Define CMD_TIMEOUT_EN to build the inter-byte timeout that abandons stalled partial frames.
//
// state        | meaning
// S_IDLE       | hunting for SYNC_BYTE
// S_CMD        | waiting for command byte
// S_ADDR       | waiting for address byte
// S_DATA       | waiting for data byte
// S_CSUM       | waiting for checksum byte, then accept or NAK
// S_SPI_START  | waiting for SPI master idle, then strobe start
// S_SPI_WAIT   | waiting for SPI transaction complete
// S_RESP       | waiting for UART transmitter idle, then strobe response
module slm_cmd_parser #(
  parameter int unsigned TIMEOUT_CLKS = 500000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  input  logic       i_tx_active,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte,
  input  logic       i_spi_busy,
  input  logic       i_spi_done,
  input  logic [7:0] i_spi_rx_byte,
  output logic       o_spi_start,
  output logic [7:0] o_spi_upper,
  output logic [7:0] o_spi_lower,
  output logic       o_busy
);

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_CSUM, S_SPI_START, S_SPI_WAIT, S_RESP
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cmd_q, cmd_nxt, addr_q, addr_nxt, data_q, data_nxt;
  logic [7:0] tx_byte_nxt, spi_upper_nxt, spi_lower_nxt;
  logic       tx_dv_nxt, spi_start_nxt;
  logic       frame_ok;
  logic       timeout;

  if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
    $error("slm_cmd_parser: TIMEOUT_CLKS must be at least 2");
  end

  assign frame_ok = ((cmd_q ^ addr_q ^ data_q) == i_rx_byte) &&
                    ((cmd_q == CMD_WR) || (cmd_q == CMD_RD));
  assign o_busy   = (state != S_IDLE);

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] to_cnt;
  logic             in_frame;

  assign in_frame = (state == S_CMD) || (state == S_ADDR) ||
                    (state == S_DATA) || (state == S_CSUM);
  assign timeout  = in_frame && !i_rx_dv && (to_cnt == CNT_LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset || !in_frame || i_rx_dv || timeout) to_cnt <= '0;
    else                                            to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    cmd_nxt       = cmd_q;
    addr_nxt      = addr_q;
    data_nxt      = data_q;
    tx_byte_nxt   = o_tx_byte;
    spi_upper_nxt = o_spi_upper;
    spi_lower_nxt = o_spi_lower;
    tx_dv_nxt     = 1'b0;
    spi_start_nxt = 1'b0;
    case (state)
      S_IDLE: if (i_rx_dv && (i_rx_byte == SYNC_BYTE)) state_nxt = S_CMD;
      S_CMD:  if (i_rx_dv) begin cmd_nxt  = i_rx_byte; state_nxt = S_ADDR; end
      S_ADDR: if (i_rx_dv) begin addr_nxt = i_rx_byte; state_nxt = S_DATA; end
      S_DATA: if (i_rx_dv) begin data_nxt = i_rx_byte; state_nxt = S_CSUM; end
      S_CSUM: begin
        if (i_rx_dv) begin
          if (frame_ok) begin
            spi_upper_nxt = addr_q;
            spi_lower_nxt = (cmd_q == CMD_WR) ? data_q : 8'h00;
            state_nxt     = S_SPI_START;
          end else begin
            tx_byte_nxt = NAK;
            state_nxt   = S_RESP;
          end
        end
      end
      S_SPI_START: begin
        if (!i_spi_busy) begin
          spi_start_nxt = 1'b1;
          state_nxt     = S_SPI_WAIT;
        end
      end
      S_SPI_WAIT: begin
        if (i_spi_done) begin
          tx_byte_nxt = (cmd_q == CMD_WR) ? ACK : i_spi_rx_byte;
          state_nxt   = S_RESP;
        end
      end
      S_RESP: begin
        if (!i_tx_active) begin
          tx_dv_nxt = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (timeout) state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= S_IDLE;
      cmd_q       <= 8'h00;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      o_tx_byte   <= 8'h00;
      o_spi_upper <= 8'h00;
      o_spi_lower <= 8'h00;
      o_tx_dv     <= 1'b0;
      o_spi_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      cmd_q       <= cmd_nxt;
      addr_q      <= addr_nxt;
      data_q      <= data_nxt;
      o_tx_byte   <= tx_byte_nxt;
      o_spi_upper <= spi_upper_nxt;
      o_spi_lower <= spi_lower_nxt;
      o_tx_dv     <= tx_dv_nxt;
      o_spi_start <= spi_start_nxt;
    end
  end

endmodule

// File: tb/tb_slm_cmd_parser.sv
// tb_slm_cmd_parser: directed plus randomized frames against a frame-level reference model.
// Exercises the timeout path when CMD_TIMEOUT_EN is defined, otherwise the indefinite-wait path.
module tb_slm_cmd_parser;

  localparam int unsigned TO_CLKS = 100;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rx_dv = 1'b0;
  logic [7:0] i_rx_byte = 8'h00;
  logic       i_tx_active = 1'b0;
  logic       o_tx_dv;
  logic [7:0] o_tx_byte;
  logic       i_spi_busy = 1'b0;
  logic       i_spi_done = 1'b0;
  logic [7:0] i_spi_rx_byte = 8'h00;
  logic       o_spi_start;
  logic [7:0] o_spi_upper;
  logic [7:0] o_spi_lower;
  logic       o_busy;

  int compared = 0;
  int mismatched = 0;
  int n_start = 0;
  int n_txdv = 0;
  logic [7:0] cap_upper = 8'h00, cap_lower = 8'h00, cap_tx = 8'h00;

  typedef struct packed {
    logic       ok;
    logic [7:0] upper;
    logic [7:0] lower;
    logic [7:0] resp;
  } exp_t;

  slm_cmd_parser #(.TIMEOUT_CLKS(TO_CLKS), .SYNC_BYTE(8'hA5)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_rx_dv      (i_rx_dv),
    .i_rx_byte    (i_rx_byte),
    .i_tx_active  (i_tx_active),
    .o_tx_dv      (o_tx_dv),
    .o_tx_byte    (o_tx_byte),
    .i_spi_busy   (i_spi_busy),
    .i_spi_done   (i_spi_done),
    .i_spi_rx_byte(i_spi_rx_byte),
    .o_spi_start  (o_spi_start),
    .o_spi_upper  (o_spi_upper),
    .o_spi_lower  (o_spi_lower),
    .o_busy       (o_busy)
  );

  always #5 i_clock = ~i_clock;

  // Strobe monitor: counts pulses and captures the bytes presented with them.
  always @(negedge i_clock) begin
    if (o_spi_start === 1'b1) begin
      n_start   = n_start + 1;
      cap_upper = o_spi_upper;
      cap_lower = o_spi_lower;
    end
    if (o_tx_dv === 1'b1) begin
      n_txdv = n_txdv + 1;
      cap_tx = o_tx_byte;
    end
  end

  function automatic exp_t model(input logic [7:0] cmd, input logic [7:0] addr,
                                 input logic [7:0] data, input logic [7:0] csum,
                                 input logic [7:0] spi_rx);
    exp_t e;
    e.ok    = (csum == (cmd ^ addr ^ data)) && (cmd == 8'h01 || cmd == 8'h02);
    e.upper = addr;
    e.lower = (cmd == 8'h01) ? data : 8'h00;
    e.resp  = !e.ok ? 8'h15 : ((cmd == 8'h01) ? 8'h06 : spi_rx);
    return e;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_dv   = 1'b1;
    i_rx_byte = b;
    step();
    i_rx_dv   = 1'b0;
    i_rx_byte = 8'($urandom);
  endtask

  task automatic wait_txdv();
    int budget;
    budget = 0;
    while (n_txdv == 0 && budget < 60) begin
      step();
      budget++;
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [7:0] addr,
                           input logic [7:0] data, input logic [7:0] csum,
                           input logic [7:0] spi_rx, input int busy_cyc, input int tx_cyc);
    exp_t e;
    e = model(cmd, addr, data, csum, spi_rx);
    n_start = 0;
    n_txdv  = 0;
    send_byte(8'hA5); step($urandom_range(0, 2));
    send_byte(cmd);   step($urandom_range(0, 2));
    send_byte(addr);  step($urandom_range(0, 2));
    send_byte(data);  step($urandom_range(0, 2));
    i_spi_busy = (busy_cyc > 0);
    send_byte(csum);
    if (e.ok) begin
      if (busy_cyc == 0) begin
        check({tag, "_start_early"}, 32'(o_spi_start), 32'd0);
        step();
        check({tag, "_start_latency"}, 32'(o_spi_start), 32'd1);
      end else begin
        if (busy_cyc > 1) step(busy_cyc - 1);
        check({tag, "_start_while_busy"}, 32'(n_start), 32'd0);
        i_spi_busy = 1'b0;
        step();
        check({tag, "_start_after_busy"}, 32'(o_spi_start), 32'd1);
      end
      step();
      check({tag, "_spi_upper"}, 32'(cap_upper), 32'(e.upper));
      check({tag, "_spi_lower"}, 32'(cap_lower), 32'(e.lower));
      step($urandom_range(0, 3));
      send_byte(8'hA5);
      i_spi_done    = 1'b1;
      i_spi_rx_byte = spi_rx;
      i_tx_active   = (tx_cyc > 0);
      step();
      i_spi_done    = 1'b0;
      i_spi_rx_byte = 8'($urandom);
      if (tx_cyc > 0) begin
        step(tx_cyc);
        check({tag, "_txdv_while_active"}, 32'(n_txdv), 32'd0);
        i_tx_active = 1'b0;
      end
    end
    wait_txdv();
    step(3);
    check({tag, "_spi_start_count"}, 32'(n_start), e.ok ? 32'd1 : 32'd0);
    check({tag, "_tx_dv_count"}, 32'(n_txdv), 32'd1);
    check({tag, "_tx_byte"}, 32'(cap_tx), 32'(e.resp));
    check({tag, "_busy_after"}, 32'(o_busy), 32'd0);
  endtask

  logic [7:0] r_cmd, r_addr, r_data, r_csum, r_rx;
  int kind;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(3);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_tx_dv", 32'(o_tx_dv), 32'd0);
    check("rst_spi_start", 32'(o_spi_start), 32'd0);
    check("rst_tx_byte", 32'(o_tx_byte), 32'd0);
    check("rst_spi_upper", 32'(o_spi_upper), 32'd0);
    check("rst_spi_lower", 32'(o_spi_lower), 32'd0);
    i_reset = 1'b0;
    step(2);

    i_spi_done = 1'b1; i_spi_rx_byte = 8'h77;
    step();
    i_spi_done = 1'b0;
    step(5);
    check("idle_done_txdv", 32'(n_txdv), 32'd0);
    check("idle_done_busy", 32'(o_busy), 32'd0);

    run_frame("write",   8'h01, 8'hF8, 8'h3C, 8'hC5, 8'h00, 0, 0);
    run_frame("read",    8'h02, 8'hF8, 8'h00, 8'hFA, 8'h5A, 0, 0);
    run_frame("bad_cs",  8'h01, 8'h10, 8'h20, 8'h00, 8'h00, 0, 0);
    run_frame("bad_cmd", 8'h07, 8'h00, 8'h00, 8'h07, 8'h00, 0, 0);
    run_frame("busy",    8'h01, 8'h12, 8'h34, 8'h27, 8'h00, 20, 6);
    run_frame("no_sync", 8'h01, 8'hA5, 8'hA5, 8'h01, 8'h00, 0, 0);

    for (int i = 0; i < 14; i++) begin
      kind   = $urandom_range(0, 3);
      r_addr = 8'($urandom);
      r_data = 8'($urandom);
      r_rx   = 8'($urandom);
      case (kind)
        0:       r_cmd = 8'h01;
        1:       r_cmd = 8'h02;
        2:       r_cmd = 8'($urandom_range(1, 2));
        default: begin
          r_cmd = 8'($urandom);
          if (r_cmd == 8'h01 || r_cmd == 8'h02) r_cmd = 8'hA5;
        end
      endcase
      r_csum = r_cmd ^ r_addr ^ r_data;
      if (kind == 2) r_csum = r_csum ^ 8'($urandom_range(1, 255));
      run_frame("rand", r_cmd, r_addr, r_data, r_csum, r_rx,
                ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(2, 6),
                $urandom_range(0, 3));
    end

    // Reset mid-frame, then a clean frame must still be accepted.
    send_byte(8'hA5);
    send_byte(8'h01);
    i_reset = 1'b1; step(); i_reset = 1'b0;
    check("rst_midframe_busy", 32'(o_busy), 32'd0);
    run_frame("after_rst", 8'h02, 8'h33, 8'h44, 8'h75, 8'hC3, 0, 0);

    // Reset while waiting on the SPI master; a late done must be ignored.
    n_start = 0; n_txdv = 0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h44); send_byte(8'h55); send_byte(8'h10);
    step(3);
    i_reset = 1'b1; step(); i_reset = 1'b0;
    check("rst_spiwait_busy", 32'(o_busy), 32'd0);
    check("rst_spiwait_upper", 32'(o_spi_upper), 32'd0);
    i_spi_done = 1'b1; i_spi_rx_byte = 8'h99;
    step();
    i_spi_done = 1'b0;
    step(10);
    check("rst_spiwait_txdv", 32'(n_txdv), 32'd0);
    check("rst_spiwait_start", 32'(n_start), 32'd1);
    check("rst_spiwait_idle", 32'(o_busy), 32'd0);

`ifdef CMD_TIMEOUT_EN
    n_start = 0; n_txdv = 0;
    send_byte(8'hA5);
    send_byte(8'h01);
    step(TO_CLKS - 1);
    check("timeout_not_yet", 32'(o_busy), 32'd1);
    step();
    check("timeout_idle", 32'(o_busy), 32'd0);
    step(5);
    check("timeout_silent", 32'(n_txdv + n_start), 32'd0);
    run_frame("after_timeout", 8'h01, 8'hF8, 8'h3C, 8'hC5, 8'h00, 0, 0);
`else
    n_start = 0; n_txdv = 0;
    send_byte(8'hA5);
    send_byte(8'h01);
    step(3 * TO_CLKS);
    check("no_timeout_busy", 32'(o_busy), 32'd1);
    send_byte(8'hF8); send_byte(8'h3C); send_byte(8'hC5);
    step();
    check("no_timeout_start", 32'(o_spi_start), 32'd1);
    i_spi_done = 1'b1;
    step();
    i_spi_done = 1'b0;
    step(4);
    check("no_timeout_txdv", 32'(n_txdv), 32'd1);
    check("no_timeout_ack", 32'(cap_tx), 32'h06);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
